// File: rtl/fdiv_issue_ctrl.sv
// fdiv_issue_ctrl
// Issue controller in front of the iterative fdiv_newton divider. Core
// requests are queued in a small FIFO, launched one at a time with a single
// div_fdiv pulse, and each result is returned with its error code, tag and
// cycle count through a valid/ready response slot.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   req_*                 request channel (valid/ready, operands a/b, rm, tag)
//   div_ena, div_fdiv     divider enable and one-cycle start pulse
//   div_a, div_b, div_rm  operands of the FIFO head
//   div_busy, div_s, div_err  divider status and result
//   rsp_*                 response slot (valid/ready, result, err, tag,
//                         watchdog timeout flag, launch-to-capture cycles)
//
// Build option
//   FDIV_ISSUE_WDOG_EN    when defined, a watchdog forces a capture with a
//                         quiet NaN after WDOG_CYCLES cycles of waiting.
module fdiv_issue_ctrl #(
    parameter int DEPTH       = 2,
    parameter int TAG_W       = 4,
    parameter int WDOG_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [1:0]       req_rm,
    input  logic [TAG_W-1:0] req_tag,
    output logic             div_ena,
    output logic             div_fdiv,
    output logic [31:0]      div_a,
    output logic [31:0]      div_b,
    output logic [1:0]       div_rm,
    input  logic             div_busy,
    input  logic [31:0]      div_s,
    input  logic [2:0]       div_err,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_s,
    output logic [2:0]       rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_timeout,
    output logic [7:0]       rsp_cycles
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT_HI, S_WAIT_LO, S_CAPTURE
    } state_t;

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [1:0]       rm;
        logic [TAG_W-1:0] tag;
    } entry_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         cyc_q, cyc_d, cyc_inc;
    logic               div_ena_q, div_fdiv_q;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_s_q, rsp_s_d;
    logic [2:0]         rsp_err_q, rsp_err_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic               rsp_timeout_q, rsp_timeout_d;
    logic [7:0]         rsp_cycles_q, rsp_cycles_d;
    logic               forced_q, forced_d;
    logic               wdog_hit;

    entry_t             mem_q [DEPTH];
    entry_t             head;
    logic [DEPTH-1:0]   wr_en;
    logic               full, empty, push, pop, in_wait;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign req_ready = !full && !rst;
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == S_CAPTURE);
    assign head      = mem_q[rd_ptr_q];
    assign in_wait   = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);
    assign cyc_inc   = (cyc_q == 8'hFF) ? cyc_q : cyc_q + 8'd1;

    // Payload storage carries no reset: the pointers decide what is valid.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign wr_en[gi] = push && (wr_ptr_q == PTR_W'(gi));
            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    mem_q[gi] <= '{a: req_a, b: req_b, rm: req_rm, tag: req_tag};
                end
            end
        end
    endgenerate

`ifdef FDIV_ISSUE_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;

    // Counts cycles spent in the wait states of the current operation.
    assign wdog_d   = in_wait ? wdog_q + WD_W'(1) : '0;
    assign wdog_hit = in_wait && (wdog_q == WD_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) wdog_q <= '0;
        else     wdog_q <= wdog_d;
    end
`else
    logic wdog_unused;
    assign wdog_unused = (WDOG_CYCLES > 0);
    assign wdog_hit    = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q;
        forced_d      = forced_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_s_d       = rsp_s_q;
        rsp_err_d     = rsp_err_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_cycles_d  = rsp_cycles_q;

        case (state_q)
            S_IDLE: begin
                cyc_d    = 8'd0;
                forced_d = 1'b0;
                // div_busy low also covers a divider still draining an
                // operation abandoned by reset or by the watchdog.
                if (!empty && !div_busy && (!rsp_valid_q || rsp_ready)) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cyc_d   = cyc_inc;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                cyc_d = cyc_inc;
                // Special operands finish without ever raising busy; give up
                // waiting for it after the second WAIT_HI cycle.
                if (div_busy)            state_d = S_WAIT_LO;
                else if (cyc_q >= 8'd2)  state_d = S_CAPTURE;
            end
            S_WAIT_LO: begin
                cyc_d = cyc_inc;
                if (!div_busy) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (wdog_hit && (state_d != S_CAPTURE)) begin
            state_d  = S_CAPTURE;
            forced_d = 1'b1;
        end

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
        // A capture in the same cycle as a handshake overwrites the slot.
        if (state_q == S_CAPTURE) begin
            rsp_valid_d   = 1'b1;
            rsp_s_d       = forced_q ? 32'h7FC0_0000 : div_s;
            rsp_err_d     = div_err;
            rsp_tag_d     = head.tag;
            rsp_timeout_d = forced_q;
            rsp_cycles_d  = cyc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cyc_q         <= 8'd0;
            forced_q      <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            div_ena_q     <= 1'b0;
            div_fdiv_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_s_q       <= 32'd0;
            rsp_err_q     <= 3'd0;
            rsp_tag_q     <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_cycles_q  <= 8'd0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            forced_q      <= forced_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            div_ena_q     <= (state_d != S_IDLE);
            div_fdiv_q    <= (state_d == S_LAUNCH);
            rsp_valid_q   <= rsp_valid_d;
            rsp_s_q       <= rsp_s_d;
            rsp_err_q     <= rsp_err_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_cycles_q  <= rsp_cycles_d;
        end
    end

    assign div_ena     = div_ena_q;
    assign div_fdiv    = div_fdiv_q;
    // The head is only popped in CAPTURE, so operands hold through the op.
    assign div_a       = empty ? 32'd0 : head.a;
    assign div_b       = empty ? 32'd0 : head.b;
    assign div_rm      = empty ? 2'd0  : head.rm;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_s       = rsp_s_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_cycles  = rsp_cycles_q;

endmodule
